// File: rtl/sram2s_pkg.sv
// Shared defaults, response tag type and index helper for the dual-port SRAM arbiter.
package sram2s_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ID_W       = 3;

    typedef struct packed {
        logic            rd;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic logic [ID_W-1:0] onehot2idx(input logic [7:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sram2s_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping modulo N.
module rr_pick
    import sram2s_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    logic [N-1:0]     elig;
    logic [PTR_W-1:0] j;
    logic             found;

    always_comb begin
        elig       = valid & mask;
        gnt_onehot = '0;
        found      = 1'b0;
        j          = '0;
        for (int unsigned off = 0; off < N; off++) begin
            j = PTR_W'((32'(ptr) + off) % N);
            if (!found && elig[j]) begin
                found         = 1'b1;
                gnt_onehot[j] = 1'b1;
            end
        end
        any     = found;
        gnt_idx = PTR_W'(onehot2idx(8'(gnt_onehot)));
    end

endmodule

// File: rtl/sram2s_arbiter.sv
// Two-port round-robin arbiter in front of a dual-port SRAM with a fixed 2-edge read return path.
module sram2s_arbiter
    import sram2s_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [NREQ*DATA_W-1:0]   rsp_data,
    output logic                     sram_ce0,
    output logic [ADDR_W-1:0]        sram_a0,
    output logic [DATA_W-1:0]        sram_d0,
    output logic                     sram_we0,
    output logic [DATA_W-1:0]        sram_wem0,
    input  logic [DATA_W-1:0]        sram_q0,
    output logic                     sram_ce1,
    output logic [ADDR_W-1:0]        sram_a1,
    output logic [DATA_W-1:0]        sram_d1,
    output logic                     sram_we1,
    output logic [DATA_W-1:0]        sram_wem1,
    input  logic [DATA_W-1:0]        sram_q1
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];

    logic [PTR_W-1:0]  ptr0_q, ptr0_d, ptr1_q, ptr1_d;
    logic [ADDR_W-1:0] a0_q, a0_d, a1_q, a1_d;
    logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;
    tag_t              tag0_q, tag0_d, tag1_q, tag1_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [NREQ*DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]   valid_eff, all_ones, mask1, oh0, oh1;
    logic [PTR_W-1:0]  idx0, idx1;
    logic              any0, any1, hazard, gnt0, gnt1;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Nothing is granted while reset is held, so the SRAM sees no access.
    assign valid_eff = RST ? '0 : req_valid;
    assign all_ones  = '1;
    assign mask1     = ~oh0;

    rr_pick #(.N(NREQ)) u_pick0 (
        .valid      (valid_eff),
        .mask       (all_ones),
        .ptr        (ptr0_q),
        .gnt_onehot (oh0),
        .gnt_idx    (idx0),
        .any        (any0)
    );

    rr_pick #(.N(NREQ)) u_pick1 (
        .valid      (valid_eff),
        .mask       (mask1),
        .ptr        (ptr1_q),
        .gnt_onehot (oh1),
        .gnt_idx    (idx1),
        .any        (any1)
    );

    // Same-address pairs involving a write are serialised by dropping port1's pick.
    always_comb begin
        hazard    = any0 && any1 && (addr_arr[idx0] == addr_arr[idx1]) && (req_we[idx0] || req_we[idx1]);
        gnt0      = any0;
        gnt1      = any1 && !hazard;
        req_ready = oh0 | (gnt1 ? oh1 : '0);
    end

    always_comb begin
        sram_ce0  = gnt0;
        sram_we0  = gnt0 && req_we[idx0];
        sram_a0   = gnt0 ? addr_arr[idx0]  : a0_q;
        sram_d0   = gnt0 ? wdata_arr[idx0] : d0_q;
        sram_wem0 = '1;
        sram_ce1  = gnt1;
        sram_we1  = gnt1 && req_we[idx1];
        sram_a1   = gnt1 ? addr_arr[idx1]  : a1_q;
        sram_d1   = gnt1 ? wdata_arr[idx1] : d1_q;
        sram_wem1 = '1;
        a0_d      = sram_a0;
        d0_d      = sram_d0;
        a1_d      = sram_a1;
        d1_d      = sram_d1;
    end

    always_comb begin
        ptr0_d = ptr0_q;
        ptr1_d = ptr1_q;
        if (gnt0) ptr0_d = (idx0 == PTR_W'(NREQ-1)) ? '0 : idx0 + PTR_W'(1);
        if (gnt1) ptr1_d = (idx1 == PTR_W'(NREQ-1)) ? '0 : idx1 + PTR_W'(1);
        tag0_d.rd = gnt0 && !req_we[idx0];
        tag0_d.id = ID_W'(idx0);
        tag1_d.rd = gnt1 && !req_we[idx1];
        tag1_d.id = ID_W'(idx1);
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (tag0_q.rd && tag0_q.id == ID_W'(i)) begin
                rsp_valid_d[i]                   = 1'b1;
                rsp_data_d[i*DATA_W +: DATA_W] = sram_q0;
            end
            if (tag1_q.rd && tag1_q.id == ID_W'(i)) begin
                rsp_valid_d[i]                   = 1'b1;
                rsp_data_d[i*DATA_W +: DATA_W] = sram_q1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr0_q      <= '0;
            ptr1_q      <= '0;
            a0_q        <= '0;
            d0_q        <= '0;
            a1_q        <= '0;
            d1_q        <= '0;
            tag0_q      <= '0;
            tag1_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr0_q      <= ptr0_d;
            ptr1_q      <= ptr1_d;
            a0_q        <= a0_d;
            d0_q        <= d0_d;
            a1_q        <= a1_d;
            d1_q        <= d1_d;
            tag0_q      <= tag0_d;
            tag1_q      <= tag1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sram2s_arbiter.sv
// Bench for sram2s_arbiter: behavioural dual-port SRAM plus a transaction-level reference model.
module tb_sram2s_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata, rsp_data;
    logic                 sram_ce0, sram_ce1, sram_we0, sram_we1;
    logic [AW-1:0]        sram_a0, sram_a1;
    logic [DW-1:0]        sram_d0, sram_d1, sram_wem0, sram_wem1, sram_q0, sram_q1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram2s_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_ce0(sram_ce0), .sram_a0(sram_a0), .sram_d0(sram_d0), .sram_we0(sram_we0),
        .sram_wem0(sram_wem0), .sram_q0(sram_q0),
        .sram_ce1(sram_ce1), .sram_a1(sram_a1), .sram_d1(sram_d1), .sram_we1(sram_we1),
        .sram_wem1(sram_wem1), .sram_q1(sram_q1)
    );

    // Behavioural 1024x32 dual-port SRAM, registered read.
    bit [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (sram_ce0) begin
            if (sram_we0) mem[sram_a0] <= sram_d0 & sram_wem0;
            else          sram_q0 <= mem[sram_a0];
        end
        if (sram_ce1) begin
            if (sram_we1) mem[sram_a1] <= sram_d1 & sram_wem1;
            else          sram_q1 <= mem[sram_a1];
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_proto
        assert property (@(posedge clk) disable iff (rst)
            (req_valid[g] && !req_ready[g]) |=> (req_valid[g] && $stable(req_we[g]) &&
             $stable(req_addr[g*AW +: AW]) && $stable(req_wdata[g*DW +: DW])));
    end

    // Reference model state: golden memory, RR pointers, 2-deep response schedule.
    bit [DW-1:0]     gold [1024];
    int              m_ptr0, m_ptr1;
    logic [NREQ-1:0] st1_vld, st2_vld;
    logic [DW-1:0]   st1_data [NREQ];
    logic [DW-1:0]   st2_data [NREQ];
    logic [DW-1:0]   m_lane   [NREQ];

    logic [NREQ-1:0]    exp_ready, exp_rsp_valid, obs_ready, obs_rsp_valid;
    logic [NREQ*DW-1:0] exp_rsp_data, obs_rsp_data;
    logic               obs_ce0, obs_ce1, obs_we0, obs_we1;
    logic [AW-1:0]      obs_a0;

    function automatic bit lane_bit(input logic [NREQ-1:0] v, input int i);
        return v[i[1:0]];
    endfunction

    function automatic logic [AW-1:0] lane_addr(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    task automatic set_req(input int i, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [NREQ-1:0] m;
        m = NREQ'(1) << i;
        req_valid = v  ? (req_valid | m) : (req_valid & ~m);
        req_we    = we ? (req_we | m)    : (req_we & ~m);
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One clock: sample at the falling edge, advance the model by the handshakes of the next rising edge.
    task automatic step();
        int w0, w1, j;
        @(negedge clk);
        obs_ready = req_ready; obs_rsp_valid = rsp_valid; obs_rsp_data = rsp_data;
        obs_ce0 = sram_ce0; obs_ce1 = sram_ce1; obs_we0 = sram_we0; obs_we1 = sram_we1; obs_a0 = sram_a0;
        if (rst) begin
            m_ptr0 = 0; m_ptr1 = 0; st1_vld = '0; st2_vld = '0;
            for (int i = 0; i < NREQ; i++) m_lane[i] = '0;
            exp_ready = '0; exp_rsp_valid = '0;
        end else begin
            exp_rsp_valid = st2_vld;
            for (int i = 0; i < NREQ; i++) if (lane_bit(st2_vld, i)) m_lane[i] = st2_data[i];
            st2_vld = st1_vld; st2_data = st1_data;
            w0 = -1; w1 = -1;
            for (int o = 0; o < NREQ; o++) begin
                j = (m_ptr0 + o) % NREQ;
                if (w0 < 0 && lane_bit(req_valid, j)) w0 = j;
            end
            for (int o = 0; o < NREQ; o++) begin
                j = (m_ptr1 + o) % NREQ;
                if (w1 < 0 && j != w0 && lane_bit(req_valid, j)) w1 = j;
            end
            if (w0 >= 0 && w1 >= 0 && lane_addr(w0) == lane_addr(w1) &&
                (lane_bit(req_we, w0) || lane_bit(req_we, w1))) w1 = -1;
            exp_ready = '0; st1_vld = '0;
            foreach (st1_data[i]) st1_data[i] = '0;
            if (w0 >= 0) begin
                exp_ready |= NREQ'(1) << w0;
                if (!lane_bit(req_we, w0)) begin st1_vld |= NREQ'(1) << w0; st1_data[w0] = gold[lane_addr(w0)]; end
            end
            if (w1 >= 0) begin
                exp_ready |= NREQ'(1) << w1;
                if (!lane_bit(req_we, w1)) begin st1_vld |= NREQ'(1) << w1; st1_data[w1] = gold[lane_addr(w1)]; end
            end
            if (w0 >= 0 && lane_bit(req_we, w0)) gold[lane_addr(w0)] = req_wdata[w0*DW +: DW];
            if (w1 >= 0 && lane_bit(req_we, w1)) gold[lane_addr(w1)] = req_wdata[w1*DW +: DW];
            if (w0 >= 0) m_ptr0 = (w0 + 1) % NREQ;
            if (w1 >= 0) m_ptr1 = (w1 + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) exp_rsp_data[i*DW +: DW] = m_lane[i];
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && req_valid != '0; k++) begin
            step();
            req_valid = req_valid & ~exp_ready;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
        step();
        n_checks++; if (obs_ready !== '0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", obs_ready); end
        n_checks++; if (obs_rsp_valid !== '0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", obs_rsp_valid); end
        n_checks++; if (obs_rsp_data !== '0) begin n_errors++; $display("FAIL reset_rsp_data: got %h want 0", obs_rsp_data); end
        n_checks++; if ({obs_ce0, obs_ce1} !== 2'b00) begin n_errors++; $display("FAIL reset_ce: got %b want 00", {obs_ce0, obs_ce1}); end
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        set_req(0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
        step();
        n_checks++; if (obs_ready !== 4'b0001 || obs_we0 !== 1'b1) begin n_errors++; $display("FAIL single_wr_grant: got ready=%b we0=%b want 0001/1", obs_ready, obs_we0); end
        req_valid = '0;
        step();
        set_req(0, 1'b1, 1'b0, 10'h005, '0);
        step();
        n_checks++; if (obs_ready !== 4'b0001) begin n_errors++; $display("FAIL single_rd_grant: got %b want 0001", obs_ready); end
        req_valid = '0;
        step();
        n_checks++; if (obs_rsp_valid !== '0) begin n_errors++; $display("FAIL single_rd_early: got %b want 0000", obs_rsp_valid); end
        step();
        n_checks++; if (obs_rsp_valid !== 4'b0001) begin n_errors++; $display("FAIL single_rd_valid: got %b want 0001", obs_rsp_valid); end
        n_checks++; if (obs_rsp_data !== 128'hDEADBEEF) begin n_errors++; $display("FAIL single_rd_data: got %h want %h", obs_rsp_data, 128'hDEADBEEF); end
        step();
        n_checks++; if (obs_rsp_valid !== '0) begin n_errors++; $display("FAIL single_rd_pulse: got %b want 0000", obs_rsp_valid); end
    endtask

    task automatic test_fairness();
        int cnt [NREQ];
        foreach (cnt[i]) cnt[i] = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(16 + i), '0);
        for (int c = 1; c <= 8; c++) begin
            step();
            for (int i = 0; i < NREQ; i++) cnt[i] += int'(lane_bit(obs_ready, i));
            n_checks++; if ($countones(obs_ready) != 2 || obs_ready !== exp_ready) begin n_errors++; $display("FAIL fair_cycle%0d: got %b want %b (two grants)", c, obs_ready, exp_ready); end
            n_checks++; if (obs_rsp_valid !== exp_rsp_valid || obs_rsp_data !== exp_rsp_data) begin n_errors++; $display("FAIL fair_rsp%0d: got %b/%h want %b/%h", c, obs_rsp_valid, obs_rsp_data, exp_rsp_valid, exp_rsp_data); end
            if (c % 4 == 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    n_checks++; if (cnt[i] != 2) begin n_errors++; $display("FAIL fair_count lane%0d: got %0d grants want 2", i, cnt[i]); end
                    cnt[i] = 0;
                end
            end
        end
        drain();
    endtask

    task automatic test_write_hazard();
        pulse_reset();
        set_req(0, 1'b1, 1'b1, 10'h100, 32'h0AA);
        set_req(1, 1'b1, 1'b0, 10'h100, '0);
        step();
        n_checks++; if (obs_ready !== 4'b0001 || obs_ready !== exp_ready) begin n_errors++; $display("FAIL hazard_first: got %b want 0001", obs_ready); end
        req_valid[0] = 1'b0;
        step();
        n_checks++; if (obs_ready !== 4'b0010) begin n_errors++; $display("FAIL hazard_retry: got %b want 0010", obs_ready); end
        req_valid[1] = 1'b0;
        step();
        step();
        n_checks++; if (obs_rsp_valid !== 4'b0010) begin n_errors++; $display("FAIL hazard_rsp_valid: got %b want 0010", obs_rsp_valid); end
        n_checks++; if (obs_rsp_data[1*DW +: DW] !== 32'h0AA) begin n_errors++; $display("FAIL hazard_rsp_data: got %h want 000000aa", obs_rsp_data[1*DW +: DW]); end
    endtask

    task automatic test_same_addr_reads();
        logic [DW-1:0] v;
        v = $urandom;
        set_req(0, 1'b1, 1'b1, 10'h3FF, v);
        step();
        req_valid[0] = 1'b0;
        set_req(2, 1'b1, 1'b0, 10'h3FF, '0);
        set_req(3, 1'b1, 1'b0, 10'h3FF, '0);
        step();
        n_checks++; if (obs_ready !== 4'b1100) begin n_errors++; $display("FAIL same_addr_grant: got %b want 1100", obs_ready); end
        req_valid = '0;
        step();
        step();
        n_checks++; if (obs_rsp_valid !== 4'b1100) begin n_errors++; $display("FAIL same_addr_valid: got %b want 1100", obs_rsp_valid); end
        n_checks++; if (obs_rsp_data[2*DW +: DW] !== v || obs_rsp_data[3*DW +: DW] !== v) begin n_errors++; $display("FAIL same_addr_data: got %h/%h want %h", obs_rsp_data[2*DW +: DW], obs_rsp_data[3*DW +: DW], v); end
    endtask

    task automatic test_reset_midflight();
        set_req(2, 1'b1, 1'b0, 10'h3FF, '0);
        step();
        n_checks++; if (obs_ready !== 4'b0100) begin n_errors++; $display("FAIL midrst_pre_grant: got %b want 0100", obs_ready); end
        rst = 1'b1;
        req_valid = '0;
        set_req(1, 1'b1, 1'b0, 10'h021, '0);
        set_req(3, 1'b1, 1'b0, 10'h023, '0);
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++; if (obs_ready !== '0 || obs_rsp_valid !== '0) begin n_errors++; $display("FAIL midrst_hold%0d: got ready=%b rsp_valid=%b want 0/0", c, obs_ready, obs_rsp_valid); end
        end
        rst = 1'b0;
        step();
        n_checks++; if (obs_ready !== 4'b1010 || obs_a0 !== 10'h021) begin n_errors++; $display("FAIL midrst_ptr0: got ready=%b a0=%h want 1010/021", obs_ready, obs_a0); end
        req_valid = '0;
        step();
        n_checks++; if (obs_rsp_valid !== '0) begin n_errors++; $display("FAIL midrst_no_rsp: got %b want 0000", obs_rsp_valid); end
    endtask

    task automatic test_idle();
        req_valid = '0;
        step(); step();
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if ({obs_ce0, obs_ce1, obs_we0, obs_we1} !== 4'b0000 || obs_rsp_valid !== '0) begin
                n_errors++; $display("FAIL idle%0d: got ce=%b%b we=%b%b rsp_valid=%b want all 0", c, obs_ce0, obs_ce1, obs_we0, obs_we1, obs_rsp_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!lane_bit(req_valid, i) || lane_bit(exp_ready, i)) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(i, 1'b1, 1'($urandom_range(0, 1)), AW'(10'h200 + $urandom_range(0, 7)), $urandom);
                    else
                        set_req(i, 1'b0, 1'b0, '0, '0);
                end
            end
            step();
            n_checks++; if (obs_ready !== exp_ready) begin n_errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, obs_ready, exp_ready); end
            n_checks++; if (obs_rsp_valid !== exp_rsp_valid) begin n_errors++; $display("FAIL rand_rsp_valid c%0d: got %b want %b", c, obs_rsp_valid, exp_rsp_valid); end
            n_checks++; if (obs_rsp_data !== exp_rsp_data) begin n_errors++; $display("FAIL rand_rsp_data c%0d: got %h want %h", c, obs_rsp_data, exp_rsp_data); end
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        exp_ready = '0;
        test_reset();
        test_single_read();
        test_fairness();
        test_write_hazard();
        test_same_addr_reads();
        test_reset_midflight();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
